ling_add_arbiter: RTL and testbench
===================================

# ling_add_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one 32-bit modulo-(2^32−1) Ling node adder among NREQ requesters. Each requester presents an operand pair on a valid/ready channel. The block grants one request per cycle, registers the operands, and drives them through the combinational adder into a result register. It returns the sum with the requester id on a single valid/ready response channel. The block sits between the issuing units and the shared adder datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 2: requester id width, equal to ceil(log2(NREQ)), minimum 1
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  32*NREQ  operand A; requester i uses bits [32i+31:32i]
- req_b  in  32*NREQ  operand B; same packing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept from the consumer
- rsp_sum  out  32  modulo-(2^32−1) sum
- rsp_id  out  IDW  index of the requester that issued the operation
- busy  out  1  at least one operation is in flight (s1_valid | rsp_valid)

## Operation
- Stage 1 registers: s1_valid, s1_a, s1_b, s1_id.
- Stage 2 registers: rsp_valid, rsp_sum, rsp_id.
- rsp_sum is registered from the adder output, computed on s1_a and s1_b.
- Arithmetic, as a reference model: s = a + b, 33 bits. Result = s[31:0] + s[32], with end-around carry and no further wrap.
  - Zero has two forms. 0xFFFFFFFF + 0 = 0xFFFFFFFF. 0xFFFFFFFF + 1 = 0x00000001. 0xFFFFFFFF + 0xFFFFFFFF = 0xFFFFFFFF.
- Advance enables:
  - s2_en = ~rsp_valid | rsp_ready
  - s1_en = ~s1_valid | s2_en
- Arbitration:
  - A round-robin pointer ptr has range 0..NREQ−1.
  - When s1_en = 1, the grant goes to the first i with req_valid[i] = 1, searching from ptr upward and wrapping.
  - req_ready[i] = s1_en & granted(i). It is combinational from req_valid and state.
  - Only one bit of req_ready is ever high.
  - No request is accepted while s1_en = 0.
- On accept of requester g:
  - s1 loads {1, a_g, b_g, g}.
  - ptr ← (g + 1) mod NREQ.
  - ptr is unchanged on cycles with no accept.
- When s1_en = 1 and there is no accept, s1_valid ← 0.
- When s2_en = 1, stage 2 loads {s1_valid, adder(s1_a, s1_b), s1_id}.
- When s2_en = 0, all of stage 2 holds.
- While a response is stalled, rsp_valid, rsp_sum and rsp_id stay stable.
- A requester holds valid and its operands until it is accepted. The block does not depend on this for correctness of already-accepted data.
- Fairness: a continuously valid requester is granted within NREQ accepts.

## Timing
- Reset (asynchronous assert, synchronous release):
  - s1_valid, rsp_valid, busy, req_ready = 0
  - rsp_sum = 0, rsp_id = 0, ptr = 0
  - s1 data = 0
- Reset mid-operation discards all in-flight operations; no response is produced for them.
- Latency: accept on edge T means the response is visible (rsp_valid = 1) after edge T+1 and is consumed no earlier than edge T+2.
- Throughput: one accept per cycle while rsp_ready = 1.
- Full condition (s1_valid = 1, rsp_valid = 1, rsp_ready = 0): all req_ready = 0, and both stages hold.
- Simultaneous drain and accept: when rsp_ready = 1 and both stages are full, stage 2 takes s1, s1 takes the new request in the same cycle, and there is no bubble.
- Empty pipe: busy = 0 the cycle after the last response handshake, with no new accept.
- Pointer wrap: a grant to NREQ−1 sets ptr = 0.

## Test plan
- Reset release, single request: requester 2 sends a=0x00000005, b=0x0000000A with rsp_ready=1.
  - req_ready[2]=1 on the first valid cycle.
  - rsp_valid=1 two edges later with rsp_sum=0x0000000F and rsp_id=2.
  - busy returns to 0 afterwards.
- End-around carry boundaries:
  - 0xFFFFFFFF+0x00000001 → 0x00000001
  - 0x80000000+0x80000000 → 0x00000001
  - 0xFFFFFFFF+0xFFFFFFFF → 0xFFFFFFFF
  - 0x12345678+0xEDCBA987 → 0xFFFFFFFF
  - Plus 10k random pairs checked against the reference model.
- Round-robin: all 4 requesters continuously valid with rsp_ready=1.
  - Grant order is 0,1,2,3,0,1,... with one accept per cycle.
  - rsp_id in the same order, 2 cycles behind.
- Backpressure: stream 6 operations, drop rsp_ready for 3 cycles mid-stream.
  - Exactly 2 operations are held.
  - req_ready is all zero during the stall.
  - rsp_* is stable during the stall.
  - No loss or duplication; responses come out in accept order.
- Sparse fairness: requester 3 is continuously valid; requesters 0 and 1 toggle.
  - Requester 3 is granted at least once in every 4 accepts.
- Async reset while both stages are full and the consumer stalls:
  - Outputs go to reset values immediately.
  - No stale response appears after release.
  - ptr=0, so the first grant goes to the lowest valid requester.

Source files
------------

// File: rtl/ling_add_arbiter.sv
// ling_add_arbiter: round-robin arbiter feeding a two-stage pipelined modulo-(2^32-1) adder
module ling_add_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);
    logic            s1_valid_q, rsp_valid_q, s1_en, s2_en, found, accept;
    logic [31:0]     s1_a_q, s1_b_q, rsp_sum_q, sum_d, a_sel, b_sel;
    logic [IDW-1:0]  s1_id_q, rsp_id_q, ptr_q, ptr_d, gnt;
    logic [IDW:0]    idx;
    logic [NREQ-1:0] rot;
    logic [32:0]     raw;

    assign s2_en = ~rsp_valid_q | rsp_ready;
    assign s1_en = ~s1_valid_q | s2_en;
    // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
    assign rot = NREQ'({req_valid, req_valid} >> ptr_q);

    // Priority search from ptr upward with wrap, mapped back to an absolute index
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = {1'b0, ptr_q} + (IDW+1)'(k);
            end
        end
        gnt = (idx >= (IDW+1)'(NREQ)) ? IDW'(idx - (IDW+1)'(NREQ)) : IDW'(idx);
    end

    // Grant is suppressed while reset is held so nothing looks accepted then.
    assign req_ready = (rst_n & s1_en & found) ? (NREQ'(1) << gnt) : '0;
    assign accept    = |req_ready;
    assign ptr_d     = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    assign a_sel     = req_a[32*gnt +: 32];
    assign b_sel     = req_b[32*gnt +: 32];

    // End-around carry: the carry out of the plain sum is fed back into bit 0.
    // The raw low word cannot overflow again when the carry is set, so the
    // all-ones form of zero survives unchanged.
    assign raw   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign sum_d = raw[31:0] + {31'd0, raw[32]};

    // Stage 1 captures the granted operands, stage 2 captures the sum; both stall together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_a_q  <= a_sel;
                    s1_b_q  <= b_sel;
                    s1_id_q <= gnt;
                    ptr_q   <= ptr_d;
                end
            end
            if (s2_en) begin
                rsp_valid_q <= s1_valid_q;
                rsp_sum_q   <= sum_d;
                rsp_id_q    <= s1_id_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q | rsp_valid_q;
endmodule

// File: tb/tb_ling_add_arbiter.sv
// tb_ling_add_arbiter: scoreboard bench for the shared modulo-(2^32-1) adder arbiter
module tb_ling_add_arbiter;
    localparam int N = 4;

    typedef struct packed { logic [31:0] a, b, e; } op_t;
    typedef struct packed {
        logic [3:0]  rdy;
        logic        rv;
        logic [31:0] sum;
        logic [1:0]  id;
        logic        busy;
    } log_t;
    typedef struct packed { logic [1:0] id; logic [31:0] sum; } exp_t;

    logic            clk = 0, rst_n = 0, rsp_ready = 0, rsp_valid, busy;
    logic [N-1:0]    req_valid = '0, req_ready;
    logic [32*N-1:0] req_a = '0, req_b = '0;
    logic [31:0]     rsp_sum;
    logic [1:0]      rsp_id;

    int   n_tests = 0, n_fail = 0, n_rsp = 0;
    op_t  pend [N][$];
    exp_t sb [$];
    log_t lg [$];
    logic [31:0] cur_exp [N];
    logic [N-1:0] have = '0, acc = '0;

    ling_add_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: subtract the modulus once when the true sum exceeds 32 bits.
    function automatic logic [31:0] mref(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        t = {1'b0, a} + {1'b0, b};
        return (t > 33'h0FFFFFFFF) ? 32'(t - 33'h0FFFFFFFF) : t[31:0];
    endfunction

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            exp_t e;
            n_rsp++;
            if (sb.size() == 0) check("unexpected_rsp", {rsp_id, rsp_sum}, 64'hDEAD);
            else begin
                e = sb.pop_front();
                check("rsp", {rsp_id, rsp_sum}, {e.id, e.sum});
            end
        end
    end

    task automatic add(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        op_t o;
        o.a = a; o.b = b; o.e = e;
        pend[i].push_back(o);
    endtask

    // One clock: present operands, record accepts and outputs, then step past the edge.
    task automatic cycle(input logic rdy, input logic [N-1:0] g);
        log_t l;
        for (int i = 0; i < N; i++) begin
            if (acc[i] || !have[i]) begin
                if (pend[i].size() > 0) begin
                    op_t o;
                    o = pend[i].pop_front();
                    req_a[32*i +: 32] = o.a;
                    req_b[32*i +: 32] = o.b;
                    cur_exp[i] = o.e;
                    have[i] = 1'b1;
                end else have[i] = 1'b0;
            end
        end
        req_valid = have & g;
        rsp_ready = rdy;
        @(negedge clk);
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                exp_t e;
                e.id = 2'(i); e.sum = cur_exp[i];
                sb.push_back(e);
            end
        end
        l.rdy = req_ready; l.rv = rsp_valid; l.sum = rsp_sum; l.id = rsp_id; l.busy = busy;
        lg.push_back(l);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        have = '0; acc = '0; req_valid = '0; rsp_ready = 0;
        for (int i = 0; i < N; i++) pend[i].delete();
        sb.delete();
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_id", rsp_id, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        lg.delete();
    endtask

    initial begin
        int n0, k;
        int grants [$];
        logic [31:0] a, b;

        do_reset();

        // Single request from requester 2
        add(2, 32'h5, 32'hA, 32'hF);
        repeat (5) cycle(1, 4'hF);
        check("single_grant", lg[0].rdy, 4'b0100);
        check("single_s1_busy", {lg[1].rv, lg[1].busy}, 2'b01);
        check("single_rsp", {lg[2].rv, lg[2].id, lg[2].sum}, {1'b1, 2'd2, 32'hF});
        check("single_idle", {lg[3].rv, lg[3].busy}, 2'b00);

        // End-around carry boundaries, then random pairs against the model
        add(0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        add(0, 32'h80000000, 32'h80000000, 32'h00000001);
        add(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add(0, 32'h12345678, 32'hEDCBA987, 32'hFFFFFFFF);
        add(0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
        add(0, 32'h00000000, 32'h00000000, 32'h00000000);
        for (int i = 0; i < 10000; i++) begin
            a = $urandom; b = $urandom;
            add(0, a, b, mref(a, b));
        end
        k = 0;
        while ((have != 0 || sb.size() != 0 || pend[0].size() != 0) && k < 10200) begin
            cycle(1, 4'hF);
            k++;
        end
        check("carry_drain", {32'(sb.size()), 28'd0, have}, 0);

        // Round-robin with all requesters valid
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) add(i, 32'(16*i + r), 32'h100, mref(32'(16*i + r), 32'h100));
        repeat (14) cycle(1, 4'hF);
        for (int c = 0; c < 12; c++) check("rr_grant", lg[c].rdy, 4'b0001 << (c % 4));
        for (int c = 2; c < 14; c++) check("rr_rsp_id", {lg[c].rv, lg[c].id}, {1'b1, 2'(c - 2)});

        // Backpressure: three stalled cycles mid-stream
        do_reset();
        add(1, 32'h1, 32'h2, 32'h3);
        add(1, 32'h3, 32'h4, 32'h7);
        add(1, 32'hFFFFFFFF, 32'h2, 32'h2);
        add(1, 32'h7FFFFFFF, 32'h80000001, 32'h1);
        add(1, 32'd10, 32'd20, 32'd30);
        add(1, 32'hFFFFFFF0, 32'h20, 32'h11);
        n0 = n_rsp;
        for (int c = 0; c < 12; c++) cycle(!(c >= 3 && c <= 5), 4'hF);
        for (int c = 0; c < 3; c++) check("bp_stream_grant", lg[c].rdy, 4'b0010);
        for (int c = 3; c < 6; c++) begin
            check("bp_stall_ready", lg[c].rdy, 0);
            check("bp_stall_rsp", {lg[c].rv, lg[c].busy, lg[c].id, lg[c].sum}, {2'b11, 2'd1, 32'h7});
        end
        check("bp_drain_accept", lg[6].rdy, 4'b0010);
        check("bp_rsp_count", n_rsp - n0, 6);
        check("bp_sb_empty", sb.size(), 0);

        // Sparse fairness: requester 3 always valid, 0 and 1 toggle
        do_reset();
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < N; i++) add(i, 32'(i << 8 | r), 32'h3, mref(32'(i << 8 | r), 32'h3));
        for (int c = 0; c < 16; c++) cycle(1, c[0] ? 4'b1010 : 4'b1001);
        foreach (lg[c]) for (int i = 0; i < N; i++) if (lg[c].rdy[i]) grants.push_back(i);
        check("fair_accepts", grants.size(), 16);
        for (int w = 0; w + 4 <= grants.size(); w++)
            check("fair_window", ((grants[w] == 3) || (grants[w+1] == 3) || (grants[w+2] == 3) || (grants[w+3] == 3)), 1);

        // Asynchronous reset with both stages full and the consumer stalled
        do_reset();
        add(0, 32'h11, 32'h22, 32'h33);
        add(0, 32'h44, 32'h55, 32'h99);
        add(2, 32'h66, 32'h77, 32'hDD);
        add(2, 32'h1, 32'h1, 32'h2);
        repeat (3) cycle(0, 4'hF);
        check("full_grant0", lg[0].rdy, 4'b0001);
        check("full_grant1", lg[1].rdy, 4'b0100);
        check("full_hold", {lg[2].rdy, lg[2].rv, lg[2].busy}, {4'b0000, 2'b11});
        #3 rst_n = 0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_rsp", {rsp_id, rsp_sum}, 0);
        do_reset();
        add(1, 32'hA0, 32'h0B, 32'hAB);
        add(3, 32'hC0, 32'h0D, 32'hCD);
        n0 = n_rsp;
        repeat (6) cycle(1, 4'hF);
        check("arst_first_grant", lg[0].rdy, 4'b0010);
        check("arst_rsp_count", n_rsp - n0, 2);
        check("arst_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
